// File: rtl/rv_regfile_wb.sv
// rv_regfile_wb: integer register file with NSRC-way write-back mux and load/store address generation.
// Define RF_BYPASS_EN to overlap write-back with the next request and forward the result to it.
module rv_regfile_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NSRC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(NREG)-1:0]   rs1_sel,
  input  logic [$clog2(NREG)-1:0]   rs2_sel,
  input  logic [$clog2(NREG)-1:0]   rd_sel,
  input  logic                      wb_en,
  input  logic [$clog2(NSRC)-1:0]   wb_src,
  input  logic [1:0]                ls_mode,
  input  logic [31:0]               instr,
  input  logic [NSRC*XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data,
  output logic [XLEN-1:0]           addr,
  output logic                      opnd_valid,
  output logic                      wb_done,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, READ, WB} state_t;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  state_t state, state_nx;
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] src [NSRC];
  logic [$clog2(NREG)-1:0] rd_q;
  logic [$clog2(NSRC)-1:0] wb_src_q;
  logic wb_en_q, accept, commit, fwd_on, unused_ok;
  logic [XLEN-1:0] wb_val, rs1_v, rs2_v, imm_l, imm_s;

  for (genvar k = 0; k < NSRC; k++) assign src[k] = wb_data[k*XLEN +: XLEN];

  assign wb_val    = src[wb_src_q];
  assign commit    = state == WB && wb_en_q && rd_q != '0;
  // Forwarding only matters for a request accepted while the previous result is still being committed
  assign fwd_on    = BYP && commit;
  assign accept    = req_valid && req_ready;
  assign rs1_v     = rs1_sel == '0 ? '0 : (fwd_on && rs1_sel == rd_q) ? wb_val : regs[rs1_sel];
  assign rs2_v     = rs2_sel == '0 ? '0 : (fwd_on && rs2_sel == rd_q) ? wb_val : regs[rs2_sel];
  assign imm_l     = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s     = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign unused_ok = ^{instr[19:12], instr[6:0]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE ? (req_valid ? READ : IDLE) :
               state == READ ? WB :
               (BYP && req_valid) ? READ : IDLE;
  end

  always_comb begin
    req_ready  = state == IDLE || (BYP && state == WB);
    opnd_valid = state == READ;
    busy       = state != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rs1_data <= '0;
      rs2_data <= '0;
      addr     <= '0;
      wb_done  <= 1'b0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      wb_src_q <= '0;
    end else begin
      wb_done <= state == WB;
      if (accept) begin
        rd_q     <= rd_sel;
        wb_en_q  <= wb_en;
        wb_src_q <= wb_src;
        rs1_data <= rs1_v;
        rs2_data <= rs2_v;
        addr     <= ls_mode == 2'b01 ? imm_l + rs1_v : ls_mode == 2'b10 ? imm_s + rs1_v : addr;
      end
    end

  // Array is intentionally not reset; x0 is masked on read and never written
  always_ff @(posedge clk)
    if (commit) regs[rd_q] <= wb_val;
endmodule

// File: tb/tb_rv_regfile_wb.sv
// tb_rv_regfile_wb: scoreboard bench for rv_regfile_wb; expectations pushed on issue, popped while opnd_valid.
module tb_rv_regfile_wb;
  localparam int XLEN = 32, NREG = 32, NSRC = 4;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_ready, wb_en = 1'b0;
  logic [4:0] rs1_sel = '0, rs2_sel = '0, rd_sel = '0;
  logic [1:0] wb_src = '0, ls_mode = '0;
  logic [31:0] instr = '0;
  logic [NSRC*XLEN-1:0] wb_data = '0;
  logic [XLEN-1:0] rs1_data, rs2_data, addr;
  logic opnd_valid, wb_done, busy;
  typedef struct {logic [31:0] r1; logic [31:0] r2; logic [31:0] a;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [31:0] mdl [32];
  logic [31:0] mdl_addr = '0;
  logic prev_ov = 1'b0;
  int n_cmp = 0, n_bad = 0, exp_done = 0, done_cnt = 0, cyc = 0, last_acc = 0;

  rv_regfile_wb #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel), .wb_en(wb_en),
    .wb_src(wb_src), .ls_mode(ls_mode), .instr(instr), .wb_data(wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .addr(addr),
    .opnd_valid(opnd_valid), .wb_done(wb_done), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wb_done) done_cnt++;
    if (opnd_valid) begin
      n_cmp++;
      if (prev_ov) begin n_bad++; $display("FAIL opnd_valid_width: high for 2 cycles, required 1"); end
      if (q.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL unexpected_opnd: opnd_valid with empty scoreboard");
      end else begin
        mon_e = q.pop_front();
        n_cmp += 3;
        if (rs1_data !== mon_e.r1) begin n_bad++; $display("FAIL rs1_data: got %h required %h", rs1_data, mon_e.r1); end
        if (rs2_data !== mon_e.r2) begin n_bad++; $display("FAIL rs2_data: got %h required %h", rs2_data, mon_e.r2); end
        if (addr !== mon_e.a) begin n_bad++; $display("FAIL addr: got %h required %h", addr, mon_e.a); end
      end
    end
    prev_ov = opnd_valid;
  end

  task automatic op(input logic [4:0] r1, r2, rd, input logic we, input logic [1:0] src, ls,
                    input logic [31:0] ins, val);
    exp_t e;
    logic [31:0] im;
    int n;
    @(negedge clk);
    rs1_sel = r1; rs2_sel = r2; rd_sel = rd; wb_en = we; wb_src = src; ls_mode = ls; instr = ins;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 8) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_cmp++; n_bad++; $display("FAIL accept_timeout: req_ready stayed 0, required 1");
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    e.r1 = r1 == 0 ? 32'h0 : mdl[r1];
    e.r2 = r2 == 0 ? 32'h0 : mdl[r2];
    im = ls == 2'b01 ? {{20{ins[31]}}, ins[31:20]} : {{20{ins[31]}}, ins[31:25], ins[11:7]};
    e.a = (ls == 2'b01 || ls == 2'b10) ? im + e.r1 : mdl_addr;
    mdl_addr = e.a;
    q.push_back(e);
    if (we && rd != 0) mdl[rd] = val;
    exp_done++;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < NSRC; k++)
      wb_data[k*XLEN +: XLEN] = (k == int'(src)) ? val : val ^ (32'h1111_1111 * (k + 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || q.size() != 0) && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); #1;
    n_cmp++;
    if (busy || q.size() != 0) begin n_bad++; $display("FAIL drain: busy=%0b pending=%0d required 0/0", busy, q.size()); end
    n_cmp++;
    if (done_cnt !== exp_done) begin n_bad++; $display("FAIL wb_done_count: got %0d required %0d", done_cnt, exp_done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp += 7;
    if (rs1_data !== '0) begin n_bad++; $display("FAIL rst_rs1: got %h required 0", rs1_data); end
    if (rs2_data !== '0) begin n_bad++; $display("FAIL rst_rs2: got %h required 0", rs2_data); end
    if (addr !== '0) begin n_bad++; $display("FAIL rst_addr: got %h required 0", addr); end
    if (opnd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_opnd_valid: got %b required 0", opnd_valid); end
    if (wb_done !== 1'b0) begin n_bad++; $display("FAIL rst_wb_done: got %b required 0", wb_done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b required 0", busy); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_req_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_write_read();
    op(0, 0, 5, 1, 0, 0, 32'h0, 32'hDEADBEEF);
    op(5, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drain();
  endtask

  task automatic test_x0();
    op(0, 0, 0, 1, 3, 0, 32'h0, 32'h12345678);
    op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drain();
  endtask

  task automatic test_addr();
    op(0, 0, 2, 1, 1, 0, 32'h0, 32'h0000_1000);
    op(2, 0, 0, 0, 0, 1, 32'hFFC0_0000, 32'h0);
    op(0, 0, 2, 1, 2, 0, 32'h0, 32'hFFFF_FFFF);
    op(2, 0, 0, 0, 0, 2, 32'h0000_0080, 32'h0);
    op(2, 2, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0);
    op(2, 0, 0, 0, 0, 3, 32'h7FF0_0000, 32'h0);
    op(2, 0, 0, 0, 0, 2, 32'hFE00_0F80, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    int a_acc, gap;
    op(0, 0, 7, 1, 1, 0, 32'h0, 32'h55);
    a_acc = last_acc;
    op(7, 7, 0, 0, 0, 0, 32'h0, 32'h0);
    gap = last_acc - a_acc;
    n_cmp++;
`ifdef RF_BYPASS_EN
    if (gap !== 2) begin n_bad++; $display("FAIL b2b_gap: got %0d cycles required 2", gap); end
`else
    if (gap !== 3) begin n_bad++; $display("FAIL b2b_gap: got %0d cycles required 3", gap); end
`endif
    drain();
  endtask

  task automatic test_random();
    for (int i = 1; i < 32; i++)
      op(0, 0, 5'(i), 1, 2'($urandom_range(0, 3)), 0, 32'h0, $urandom);
    for (int i = 0; i < 24; i++)
      op(5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
         $urandom, $urandom);
    drain();
  endtask

  task automatic test_reset_wb();
    op(0, 0, 3, 1, 2, 0, 32'h0, 32'h0000_AAAA);
    drain();
    op(0, 0, 3, 1, 2, 0, 32'h0, 32'h0000_BBBB);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || opnd_valid !== 1'b0) begin n_bad++; $display("FAIL in_wb: busy=%b opnd_valid=%b required 1/0", busy, opnd_valid); end
    rst_n = 1'b0;
    mdl[3] = 32'h0000_AAAA;
    mdl_addr = '0;
    exp_done--;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst: busy=%b req_ready=%b required 0/1", busy, req_ready); end
    @(negedge clk); rst_n = 1'b1;
    op(3, 3, 0, 0, 0, 0, 32'h0, 32'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_addr();
    test_back_to_back();
    test_random();
    test_reset_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
